// File: rtl/pattern_stream_ctrl.sv
// Feeds words bit-serially into a single-bit Moore pattern detector and returns the per-word match count.
// Optional statistics outputs (stat_words, stat_matches) are built when PATTERN_STREAM_CTRL_STATS_EN is defined.
module pattern_stream_ctrl #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             det_a,
   output logic             det_reset,
   input  logic             det_y,
   output logic [CW-1:0]    out_count,
   output logic             out_valid,
   input  logic             out_ready
`ifdef PATTERN_STREAM_CTRL_STATS_EN
   ,
   output logic [15:0]      stat_words,
   output logic [15:0]      stat_matches
`endif
);

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

   localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_shifted;
   logic [CW-1:0]    bitcnt;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_sampled;

   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   // count_sampled is the running count with the current det_y folded in, saturating at WIDTH.
   always_comb begin
      shreg_shifted = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
      count_sampled = count;
      if (det_y && (count != WIDTH_C))
         count_sampled = count + 1'b1;
   end

`ifdef PATTERN_STREAM_CTRL_STATS_EN
   logic [16:0] matches_sum;
   assign matches_sum = {1'b0, stat_matches} + 17'(out_count);
`endif

   // NOTE: every output is a register loaded with the value belonging to the state being
   // entered, so outputs change only at the clock edge and det_y never reaches a port directly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_count <= '0;
         det_reset <= 1'b1;
         det_a     <= 1'b0;
         shreg     <= '0;
         bitcnt    <= '0;
         count     <= '0;
`ifdef PATTERN_STREAM_CTRL_STATS_EN
         stat_words   <= '0;
         stat_matches <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  shreg     <= in_data;
                  count     <= '0;
                  bitcnt    <= WIDTH_C;
                  det_a     <= head_bit(in_data);
                  det_reset <= 1'b0;
                  in_ready  <= 1'b0;
                  state     <= SHIFT;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SHIFT: begin
               // The first SHIFT cycle still shows the detector's reset output.
               if (bitcnt != WIDTH_C)
                  count <= count_sampled;
               shreg  <= shreg_shifted;
               bitcnt <= bitcnt - 1'b1;
               if (bitcnt == CW'(1)) begin
                  det_a <= 1'b0;
                  state <= DRAIN;
               end else begin
                  det_a <= head_bit(shreg_shifted);
               end
            end
            DRAIN: begin
               out_count <= count_sampled;
               out_valid <= 1'b1;
               det_reset <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
`ifdef PATTERN_STREAM_CTRL_STATS_EN
                  if (stat_words != 16'hFFFF)
                     stat_words <= stat_words + 16'd1;
                  stat_matches <= matches_sum[16] ? 16'hFFFF : matches_sum[15:0];
`endif
               end
            end
         endcase
      end
   end

endmodule
